sdhost_cmd_sequencer: RTL and testbench

Command-path controller for the SD host. It accepts a command issue from the CPU register side and launches it on the CMD engine. It then supervises completion, response handover and timeout, and reports status bits: Command Inhibit (CMD), the Command Complete interrupt and the Command Timeout error. It sits between the CPU-facing registers (argument, command, present state, interrupt and error status) and the CMD line engine.

---
 rtl/sdhost_cmd_sequencer_if.sv | 21 ++
 rtl/sdhost_cmd_sequencer.sv | 115 +++++++++++
 tb/tb_sdhost_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdhost_cmd_sequencer_if.sv
// Link between the command sequencer and the CMD line engine: launch strobe,
// latched command fields, completion and response handover.
interface sdhost_cmd_sequencer_if;
  logic         new_command;
  logic [5:0]   cmd_index_out;
  logic [31:0]  cmd_argument_out;
  logic         cmd_done;
  logic         resp_valid;
  logic [127:0] cmd_response;
  logic         resp_ack;

  modport master (
    output new_command, cmd_index_out, cmd_argument_out, resp_ack,
    input  cmd_done, resp_valid, cmd_response
  );

  modport slave (
    input  new_command, cmd_index_out, cmd_argument_out, resp_ack,
    output cmd_done, resp_valid, cmd_response
  );
endinterface

// File: rtl/sdhost_cmd_sequencer.sv
// SD host command-path controller: launches a CPU-issued command on the CMD
// engine, supervises completion, response capture and timeout, reports status.
module sdhost_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cmd_issue,
  input  logic [5:0]                    cmd_index_in,
  input  logic [31:0]                   cmd_argument_in,
  input  logic [1:0]                    response_type_in,
  input  logic                          timeout_enable_in,
  sdhost_cmd_sequencer_if.master        engine,
  output logic                          resp_wr,
  output logic [127:0]                  resp_data,
  output logic                          cmd_inhibit,
  output logic                          int_cmd_complete,
  output logic                          err_cmd_timeout,
  output logic                          issue_rejected
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_DONE, WAIT_RESP, COMPLETE, ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [5:0]    index_reg;
  logic [31:0]   argument_reg;
  logic [1:0]    type_reg;
  logic          timeout_en_reg;
  logic          resp_seen_reg;
  logic [15:0]   timer_reg;
  logic [127:0]  resp_data_reg;
  logic          resp_pulse_reg;
  logic          rejected_reg;

  logic in_wait;
  logic capture;
  logic expired;

  assign in_wait = (state_reg == WAIT_DONE) || (state_reg == WAIT_RESP);
  assign expired = in_wait && timeout_en_reg && (timer_reg == TIMEOUT_LAST);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE:      if (cmd_issue) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: begin
        capture = engine.resp_valid;
        // A response arriving on the same edge as cmd_done already satisfies the command.
        if (engine.cmd_done)
          state_next = (type_reg == 2'b00 || resp_seen_reg || engine.resp_valid)
                       ? COMPLETE : WAIT_RESP;
      end
      WAIT_RESP: begin
        capture = engine.resp_valid;
        if (engine.resp_valid) state_next = COMPLETE;
      end
      COMPLETE:  state_next = IDLE;
      ERROR:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    // Only finishing the command beats the expiry; the timer never revisits TIMEOUT_LAST.
    if (expired && state_next != COMPLETE) state_next = ERROR;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      argument_reg   <= '0;
      type_reg       <= '0;
      timeout_en_reg <= 1'b0;
      resp_seen_reg  <= 1'b0;
      timer_reg      <= '0;
      resp_data_reg  <= '0;
      resp_pulse_reg <= 1'b0;
      rejected_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      resp_pulse_reg <= capture;
      rejected_reg   <= cmd_issue && (state_reg != IDLE);
      if (capture) resp_data_reg <= engine.cmd_response;
      if (state_reg == IDLE && cmd_issue) begin
        index_reg      <= cmd_index_in;
        argument_reg   <= cmd_argument_in;
        type_reg       <= response_type_in;
        timeout_en_reg <= timeout_enable_in;
        resp_seen_reg  <= 1'b0;
      end else if (state_reg == WAIT_DONE && capture) begin
        resp_seen_reg  <= 1'b1;
      end
      if (state_reg == LAUNCH)
        timer_reg <= '0;
      else if (in_wait && timer_reg != 16'hFFFF)
        timer_reg <= timer_reg + 16'd1;
    end
  end

  assign engine.new_command      = (state_reg == LAUNCH);
  assign engine.cmd_index_out    = index_reg;
  assign engine.cmd_argument_out = argument_reg;
  assign engine.resp_ack         = resp_pulse_reg;
  assign resp_wr                 = resp_pulse_reg;
  assign resp_data               = resp_data_reg;
  assign cmd_inhibit             = (state_reg != IDLE);
  assign int_cmd_complete        = (state_reg == COMPLETE);
  assign err_cmd_timeout         = (state_reg == ERROR);
  assign issue_rejected          = rejected_reg;

endmodule

// File: tb/tb_sdhost_cmd_sequencer.sv
// Directed bench for sdhost_cmd_sequencer: issue, response handover, timeout,
// expiry tie, rejected issue and mid-command reset.
module tb_sdhost_cmd_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_issue;
  logic [5:0]   cmd_index_in;
  logic [31:0]  cmd_argument_in;
  logic [1:0]   response_type_in;
  logic         timeout_enable_in;
  logic         resp_wr;
  logic [127:0] resp_data;
  logic         cmd_inhibit;
  logic         int_cmd_complete;
  logic         err_cmd_timeout;
  logic         issue_rejected;

  sdhost_cmd_sequencer_if engine_bus ();

  sdhost_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_issue        (cmd_issue),
    .cmd_index_in     (cmd_index_in),
    .cmd_argument_in  (cmd_argument_in),
    .response_type_in (response_type_in),
    .timeout_enable_in(timeout_enable_in),
    .engine           (engine_bus),
    .resp_wr          (resp_wr),
    .resp_data        (resp_data),
    .cmd_inhibit      (cmd_inhibit),
    .int_cmd_complete (int_cmd_complete),
    .err_cmd_timeout  (err_cmd_timeout),
    .issue_rejected   (issue_rejected)
  );

  always #5 clock = ~clock;

  int err_count   = 0;
  int check_count = 0;
  int cnt_new, cnt_complete, cnt_err, cnt_wr, cnt_ack, cnt_rej;
  int wait_steps;

  task automatic check_value(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and tally output pulses.
  task automatic step();
    @(posedge clock);
    #1;
    cnt_new      += int'(engine_bus.new_command);
    cnt_complete += int'(int_cmd_complete);
    cnt_err      += int'(err_cmd_timeout);
    cnt_wr       += int'(resp_wr);
    cnt_ack      += int'(engine_bus.resp_ack);
    cnt_rej      += int'(issue_rejected);
  endtask

  task automatic clear_counts();
    cnt_new = 0; cnt_complete = 0; cnt_err = 0;
    cnt_wr = 0; cnt_ack = 0; cnt_rej = 0;
  endtask

  // Present one issue pulse; returns in the LAUNCH cycle.
  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] rtype, input logic ten);
    clear_counts();
    cmd_issue = 1'b1; cmd_index_in = idx; cmd_argument_in = arg;
    response_type_in = rtype; timeout_enable_in = ten;
    step();
    cmd_issue = 1'b0;
    $display("issue idx=%0d arg=%h type=%b ten=%0b", idx, arg, rtype, ten);
  endtask

  initial begin
    reset = 1'b0; cmd_issue = 1'b0; cmd_index_in = '0; cmd_argument_in = '0;
    response_type_in = '0; timeout_enable_in = 1'b0;
    engine_bus.cmd_done = 1'b0; engine_bus.resp_valid = 1'b0; engine_bus.cmd_response = '0;
    clear_counts();
    step(); step();
    reset = 1'b1;
    check_value("rst_inhibit", cmd_inhibit, 0);
    check_value("rst_new", engine_bus.new_command, 0);
    check_value("rst_resp_data", resp_data, 0);
    check_value("rst_arg", engine_bus.cmd_argument_out, 0);

    // resp_valid while idle is ignored
    engine_bus.resp_valid = 1'b1; engine_bus.cmd_response = 128'hFFFF;
    step();
    engine_bus.resp_valid = 1'b0;
    check_value("idle_ack", engine_bus.resp_ack, 0);
    check_value("idle_data", resp_data, 0);

    // Type 00, cmd_done a few WAIT cycles after launch
    issue(6'd0, 32'h0, 2'b00, 1'b1);
    check_value("t1_new", engine_bus.new_command, 1);
    check_value("t1_inhibit", cmd_inhibit, 1);
    check_value("t1_idx", engine_bus.cmd_index_out, 0);
    step();
    check_value("t1_new_off", engine_bus.new_command, 0);
    step(); step(); step();
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t1_complete", int_cmd_complete, 1);
    check_value("t1_inhibit_c", cmd_inhibit, 1);
    step();
    check_value("t1_inhibit_off", cmd_inhibit, 0);
    check_value("t1_cnt_new", cnt_new, 1);
    check_value("t1_cnt_complete", cnt_complete, 1);
    check_value("t1_cnt_wr", cnt_wr, 0);

    // Type 10, response three cycles after cmd_done
    issue(6'd17, 32'hDEADBEEF, 2'b10, 1'b1);
    check_value("t2_arg", engine_bus.cmd_argument_out, 32'hDEADBEEF);
    step();
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t2_wait_resp", cmd_inhibit, 1);
    step(); step();
    engine_bus.resp_valid = 1'b1; engine_bus.cmd_response = 128'h1234;
    step();
    engine_bus.resp_valid = 1'b0;
    check_value("t2_wr", resp_wr, 1);
    check_value("t2_ack", engine_bus.resp_ack, 1);
    check_value("t2_data", resp_data, 128'h1234);
    check_value("t2_complete", int_cmd_complete, 1);
    step(); step();
    check_value("t2_cnt_wr", cnt_wr, 1);
    check_value("t2_cnt_ack", cnt_ack, 1);
    check_value("t2_cnt_complete", cnt_complete, 1);

    // Type 10, response and cmd_done on the same edge
    issue(6'd18, 32'h12345678, 2'b10, 1'b1);
    step();
    engine_bus.cmd_done = 1'b1; engine_bus.resp_valid = 1'b1;
    engine_bus.cmd_response = 128'hAAAA_0000_0000_0000_0000_0000_0000_5555;
    step();
    engine_bus.cmd_done = 1'b0; engine_bus.resp_valid = 1'b0;
    check_value("t3_data", resp_data, 128'hAAAA_0000_0000_0000_0000_0000_0000_5555);
    check_value("t3_complete", int_cmd_complete, 1);
    step(); step(); step();
    check_value("t3_cnt_wr", cnt_wr, 1);
    check_value("t3_cnt_complete", cnt_complete, 1);
    check_value("t3_inhibit", cmd_inhibit, 0);

    // Timeout enabled, no cmd_done: 8 WAIT cycles then ERROR
    issue(6'd3, 32'h55, 2'b10, 1'b1);
    wait_steps = 0;
    while (!err_cmd_timeout && wait_steps < 30) begin
      step();
      wait_steps++;
    end
    check_value("t4_err_delay", wait_steps, 9);
    step();
    check_value("t4_inhibit", cmd_inhibit, 0);
    check_value("t4_cnt_err", cnt_err, 1);
    check_value("t4_cnt_complete", cnt_complete, 0);
    check_value("t4_cnt_wr", cnt_wr, 0);

    // Timeout disabled: 100 cycles without error
    issue(6'd3, 32'h55, 2'b00, 1'b0);
    for (int i = 0; i < 100; i++) step();
    check_value("t5_inhibit", cmd_inhibit, 1);
    check_value("t5_cnt_err", cnt_err, 0);
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t5_complete", int_cmd_complete, 1);
    step();

    // cmd_done exactly on the expiry edge
    issue(6'd5, 32'h77, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) step();
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t6_complete", int_cmd_complete, 1);
    check_value("t6_err", err_cmd_timeout, 0);
    step(); step();
    check_value("t6_cnt_err", cnt_err, 0);
    check_value("t6_cnt_complete", cnt_complete, 1);

    // Second issue while busy is rejected
    issue(6'd9, 32'hCAFE0001, 2'b00, 1'b1);
    step();
    cmd_issue = 1'b1; cmd_index_in = 6'd33; cmd_argument_in = 32'hBAD0BAD0;
    step();
    cmd_issue = 1'b0;
    check_value("t7_rejected", issue_rejected, 1);
    check_value("t7_arg", engine_bus.cmd_argument_out, 32'hCAFE0001);
    check_value("t7_idx", engine_bus.cmd_index_out, 9);
    step();
    check_value("t7_rejected_off", issue_rejected, 0);
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t7_complete", int_cmd_complete, 1);
    step();
    check_value("t7_cnt_rej", cnt_rej, 1);
    check_value("t7_cnt_complete", cnt_complete, 1);

    // Reset during WAIT_RESP aborts silently
    issue(6'd12, 32'h1111, 2'b01, 1'b1);
    step();
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_value("t8_inhibit", cmd_inhibit, 0);
    check_value("t8_arg", engine_bus.cmd_argument_out, 0);
    check_value("t8_idx", engine_bus.cmd_index_out, 0);
    check_value("t8_resp_data", resp_data, 0);
    for (int i = 0; i < 12; i++) step();
    check_value("t8_cnt_complete", cnt_complete, 0);
    check_value("t8_cnt_err", cnt_err, 0);
    issue(6'd2, 32'h2222, 2'b00, 1'b1);
    check_value("t8_new", engine_bus.new_command, 1);
    check_value("t8_new_arg", engine_bus.cmd_argument_out, 32'h2222);
    step();
    engine_bus.cmd_done = 1'b1;
    step();
    engine_bus.cmd_done = 1'b0;
    check_value("t8_complete", int_cmd_complete, 1);
    step();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
